xpmwrap_spram_req_ctrl: RTL

- Request/response front-end that sits directly upstream of the byte-write single-port RAM wrapper.
- Converts a valid/ready request stream (read or byte-masked write) into RAM port A strobes.
- Tracks the RAM's fixed 2-cycle read latency and returns read data on a valid/ready response stream.
- Uses credit-based flow control and an internal response FIFO, so backpressure never loses read data.

---
 rtl/xpmwrap_spram_pkg.sv | 22 ++
 rtl/xpmwrap_spram_req_ctrl_if.sv | 37 +++
 rtl/xpmwrap_sync_fifo.sv | 55 +++++
 rtl/xpmwrap_spram_req_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/xpmwrap_spram_pkg.sv
// Shared types and constants for the single-port RAM wrapper and its request front-end.
package xpmwrap_spram_pkg;

    localparam int SPRAM_ADDR_WIDTH   = 6;
    localparam int SPRAM_DATA_WIDTH   = 32;
    localparam int SPRAM_BYTE_WIDTH   = 8;
    localparam int SPRAM_NB           = SPRAM_DATA_WIDTH / SPRAM_BYTE_WIDTH;
    // Must track READ_LATENCY_A of the RAM wrapper.
    localparam int SPRAM_READ_LATENCY = 2;

    typedef struct packed {
        logic [SPRAM_NB-1:0]         we;
        logic [SPRAM_ADDR_WIDTH-1:0] addr;
        logic [SPRAM_DATA_WIDTH-1:0] wdata;
    } spram_req_t;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/xpmwrap_spram_req_ctrl_if.sv
// Request, response and RAM port A signals of the request controller.
interface xpmwrap_spram_req_ctrl_if
    import xpmwrap_spram_pkg::*;
#(
    parameter int ADDR_WIDTH_A = SPRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH_A = SPRAM_DATA_WIDTH,
    parameter int NB_A         = SPRAM_NB
);
    logic                    req_valid;
    logic                    req_ready;
    logic [NB_A-1:0]         req_we;
    logic [ADDR_WIDTH_A-1:0] req_addr;
    logic [DATA_WIDTH_A-1:0] req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH_A-1:0] rsp_rdata;
    logic                    mem_ena;
    logic [NB_A-1:0]         mem_wea;
    logic [ADDR_WIDTH_A-1:0] mem_addra;
    logic [DATA_WIDTH_A-1:0] mem_dina;
    logic                    mem_regcea;
    logic                    mem_rsta;
    logic [DATA_WIDTH_A-1:0] mem_douta;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_ena, mem_wea, mem_addra, mem_dina, mem_regcea, mem_rsta
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_ena, mem_wea, mem_addra, mem_dina, mem_regcea, mem_rsta
    );

endinterface

// File: rtl/xpmwrap_sync_fifo.sv
// Synchronous FIFO with registered storage and a head-of-queue output.
module xpmwrap_sync_fifo
    import xpmwrap_spram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop & ~empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign dout   = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Push while full is only safe when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/xpmwrap_spram_req_ctrl.sv
// Valid/ready front-end for the byte-write single-port RAM: drives port A and
// returns read data through a credit-protected response FIFO.
module xpmwrap_spram_req_ctrl
    import xpmwrap_spram_pkg::*;
#(
    parameter int ADDR_WIDTH_A       = SPRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH_A       = SPRAM_DATA_WIDTH,
    parameter int BYTE_WRITE_WIDTH_A = SPRAM_BYTE_WIDTH,
    parameter int RSP_DEPTH          = 4
) (
    input logic clka,
    input logic rsta,
    xpmwrap_spram_req_ctrl_if.slave bus
);
    localparam int NB_A = DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
    localparam int CW   = count_width(RSP_DEPTH);
    localparam int OW   = count_width(SPRAM_READ_LATENCY);
    localparam int SW   = CW + 1;

    logic          accept;
    logic          rd_accept;
    logic          rd_s1;
    logic          rd_s2;
    logic          credit_ok;
    logic [OW-1:0] outstanding;
    logic [SW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    // Every read in the pipe already owns a FIFO slot, so the sum bounds occupancy.
    assign outstanding = OW'(rd_s1) + OW'(rd_s2);
    assign inflight    = SW'(outstanding) + SW'(fifo_count);
    assign credit_ok   = inflight < SW'(RSP_DEPTH);

    assign bus.req_ready = ~rsta & credit_ok;
    assign accept        = bus.req_valid & bus.req_ready;
    assign rd_accept     = accept & ~|bus.req_we;

    assign bus.mem_ena    = accept;
    assign bus.mem_wea    = bus.req_we & {NB_A{accept}};
    assign bus.mem_addra  = bus.req_addr;
    assign bus.mem_dina   = bus.req_wdata;
    assign bus.mem_regcea = rd_s1;
    assign bus.mem_rsta   = rsta;

    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
        end else begin
            rd_s1 <= rd_accept;
            rd_s2 <= rd_s1;
        end
    end

    assign bus.rsp_valid = ~fifo_empty;

    xpmwrap_sync_fifo #(
        .WIDTH (DATA_WIDTH_A),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clka),
        .rst   (rsta),
        .push  (rd_s2),
        .pop   (bus.rsp_valid & bus.rsp_ready),
        .din   (bus.mem_douta),
        .dout  (bus.rsp_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
